// File: rtl/clk_div_prog_if.sv
// Control and status bundle for the programmable clock divider.
// The master drives run/reload controls; the slave (divider) returns the divided clock and status.
interface clk_div_prog_if #(
  parameter int DIV_W = 8
);
  logic             en;
  logic             load;
  logic [DIV_W-1:0] div_val;
  logic             clk_out;
  logic             tick;
  logic [DIV_W-1:0] div_cur;

  modport master (
    output en, load, div_val,
    input  clk_out, tick, div_cur
  );

  modport slave (
    input  en, load, div_val,
    output clk_out, tick, div_cur
  );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with glitch-free divisor reload at period wrap.
// Optional macro CLK_DIV_ODD_DUTY50_EN adds a negedge stage giving exact 50% duty for odd divisors.
module clk_div_prog #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  clk_div_prog_if.slave  bus
);
  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  logic [DIV_W-1:0] cur_div;
  logic [DIV_W-1:0] pend_div;
  logic             pend_vld;
  logic [DIV_W-1:0] cnt;
  logic             clk_out_reg;
  logic             tick_reg;

  logic [DIV_W-1:0] div_clamp;
  logic [DIV_W-1:0] div_idle;
  logic [DIV_W-1:0] half;
  logic [DIV_W-1:0] cnt_inc;
  logic             wrap;

  always_comb begin
    div_clamp = (bus.div_val < DIV_MIN) ? DIV_MIN : bus.div_val;
    // While stopped, any new divisor is adopted at once so re-enable wraps on the first edge.
    div_idle  = bus.load ? div_clamp : (pend_vld ? pend_div : cur_div);
    half      = cur_div >> 1;
    cnt_inc   = cnt + ONE;
    wrap      = (cnt == cur_div - ONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_div     <= DEF_DIV;
      pend_div    <= DEF_DIV;
      pend_vld    <= 1'b0;
      cnt         <= DEF_DIV - ONE;
      clk_out_reg <= 1'b0;
      tick_reg    <= 1'b0;
    end else if (!bus.en) begin
      cur_div     <= div_idle;
      pend_vld    <= 1'b0;
      cnt         <= div_idle - ONE;
      clk_out_reg <= 1'b0;
      tick_reg    <= 1'b0;
    end else if (wrap) begin
      cnt         <= '0;
      clk_out_reg <= 1'b1;
      tick_reg    <= 1'b1;
      pend_vld    <= 1'b0;
      if (bus.load) begin
        cur_div <= div_clamp;
      end else if (pend_vld) begin
        cur_div <= pend_div;
      end
    end else begin
      cnt         <= cnt_inc;
      clk_out_reg <= (cnt_inc < half);
      tick_reg    <= 1'b0;
      if (bus.load) begin
        pend_div <= div_clamp;
        pend_vld <= 1'b1;
      end
    end
  end

`ifdef CLK_DIV_ODD_DUTY50_EN
  logic clk_out_n;

  // Half-cycle delayed copy stretches the high phase by 0.5 cycle for odd divisors.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_out_n <= 1'b0;
    end else begin
      clk_out_n <= clk_out_reg;
    end
  end

  assign bus.clk_out = cur_div[0] ? (clk_out_reg | clk_out_n) : clk_out_reg;
`else
  assign bus.clk_out = clk_out_reg;
`endif

  assign bus.tick    = tick_reg;
  assign bus.div_cur = cur_div;
endmodule

// File: tb/tb_clk_div_prog.sv
// Directed table-driven bench for clk_div_prog plus hand sequences for async reset and pending loss.
module tb_clk_div_prog;
  localparam int DIV_W = 8;

  logic clk;
  logic rst_n;

  clk_div_prog_if #(.DIV_W(DIV_W)) bus ();

  clk_div_prog #(.DIV_W(DIV_W), .DEFAULT_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       load;
    logic [7:0] div_val;
    logic       exp_out;
    logic       exp_tick;
    logic [7:0] exp_cur;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic add(input logic en, input logic ld, input int dv,
                     input logic out, input logic tk, input int cur);
    vec_t v;
    v.en = en; v.load = ld; v.div_val = 8'(dv);
    v.exp_out = out; v.exp_tick = tk; v.exp_cur = 8'(cur);
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s step %0d got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Port value for the posedge register value 'out'; the odd-duty build ORs in the previous cycle's value.
  function automatic logic port_exp(input logic out, input logic prev_out, input logic [7:0] cur);
`ifdef CLK_DIV_ODD_DUTY50_EN
    return cur[0] ? (out | prev_out) : out;
`else
    return out;
`endif
  endfunction

  initial begin
    logic prev_out;

    // /4 from reset
    add(1,0,0, 1,1,4); add(1,0,0, 1,0,4); add(1,0,0, 0,0,4); add(1,0,0, 0,0,4);
    add(1,0,0, 1,1,4); add(1,0,0, 1,0,4);
    // load 5 at cnt=1: current period stays 4
    add(1,1,5, 0,0,4); add(1,0,0, 0,0,4); add(1,0,0, 1,1,5);
    add(1,0,0, 1,0,5); add(1,0,0, 0,0,5); add(1,0,0, 0,0,5); add(1,0,0, 0,0,5);
    add(1,0,0, 1,1,5);
    // load 6, then 3, then 8 in the wrap cycle
    add(1,1,6, 1,0,5); add(1,1,3, 0,0,5); add(1,0,0, 0,0,5); add(1,0,0, 0,0,5);
    add(1,1,8, 1,1,8);
    for (int i = 0; i < 3; i++) add(1,0,0, 1,0,8);
    for (int i = 0; i < 4; i++) add(1,0,0, 0,0,8);
    add(1,0,0, 1,1,8);
    // load 0 clamps to 2
    add(1,1,0, 1,0,8); add(1,0,0, 1,0,8); add(1,0,0, 1,0,8);
    for (int i = 0; i < 4; i++) add(1,0,0, 0,0,8);
    add(1,0,0, 1,1,2);
    // load 1 clamps to 2
    add(1,1,1, 0,0,2); add(1,0,0, 1,1,2); add(1,0,0, 0,0,2); add(1,0,0, 1,1,2);
    // odd divisor 3
    add(1,1,3, 0,0,2); add(1,0,0, 1,1,3); add(1,0,0, 0,0,3); add(1,0,0, 0,0,3);
    add(1,0,0, 1,1,3);
    // en low for 10 cycles starting in the high phase, then immediate wrap
    for (int i = 0; i < 10; i++) add(0,0,0, 0,0,3);
    add(1,0,0, 1,1,3);
    // pending divisor applied while stopped
    add(1,1,6, 0,0,3); add(0,0,0, 0,0,6); add(1,0,0, 1,1,6);
    // pending 7 that the reset below must discard
    add(1,1,7, 1,0,6);

    bus.en = 1'b0; bus.load = 1'b0; bus.div_val = '0;
    rst_n = 1'b0;
    #12;
    chk("rst_clk_out", 0, int'(bus.clk_out), 0);
    chk("rst_tick",    0, int'(bus.tick),    0);
    chk("rst_div_cur", 0, int'(bus.div_cur), 4);
    @(negedge clk);
    rst_n = 1'b1;

    prev_out = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      bus.en = vecs[i].en; bus.load = vecs[i].load; bus.div_val = vecs[i].div_val;
      step();
      chk("clk_out", i, int'(bus.clk_out),
          int'(port_exp(vecs[i].exp_out, prev_out, vecs[i].exp_cur)));
      chk("tick",    i, int'(bus.tick),    int'(vecs[i].exp_tick));
      chk("div_cur", i, int'(bus.div_cur), int'(vecs[i].exp_cur));
      prev_out = vecs[i].exp_out;
    end
    bus.load = 1'b0; bus.div_val = '0;

    // Async reset mid-high-phase: outputs clear before the next edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_clk_out", 100, int'(bus.clk_out), 0);
    chk("async_rst_tick",    100, int'(bus.tick),    0);
    chk("async_rst_div_cur", 100, int'(bus.div_cur), 4);
    @(negedge clk);
    rst_n = 1'b1;

    // Counter restarted at DEFAULT_DIV-1: first edge wraps; pending 7 lost so period stays 4
    step();
    chk("post_rst_wrap_out",  101, int'(bus.clk_out), 1);
    chk("post_rst_wrap_tick", 101, int'(bus.tick),    1);
    step(); chk("post_rst_c1", 102, int'(bus.clk_out), 1);
    step(); chk("post_rst_c2", 103, int'(bus.clk_out), 0);
    step(); chk("post_rst_c3", 104, int'(bus.tick),    0);
    step();
    chk("post_rst_rewrap_tick", 105, int'(bus.tick),    1);
    chk("post_rst_div_cur",     105, int'(bus.div_cur), 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
